dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
Round-robin arbiter and sequencer for a WIDTH-bit register bank built from set/clear/load D flip-flops. Each flop has St (set), clr (clear, dominant over St), Id (load enable) and D inputs. Four requesters share the bank. The block grants one requester at a time and drives the bank's per-bit control lines for exactly one clock, then acknowledges.

Parameters:
WIDTH, 8, number of flops in the controlled bank (1..32)

Ports:
clk  input  1  system clock, rising-edge
clr_n  input  1  synchronous active-low reset
req  input  4  request per requester (bit i = requester i)
op  input  8  2-bit op per requester, op[2i+1:2i]: 00 load, 01 set, 10 clear, 11 nop
din  input  4*WIDTH  data/mask per requester, din[WIDTH*i +: WIDTH]
gnt  output  4  one-hot grant, registered
reg_st  output  WIDTH  per-bit St to bank
reg_clr  output  WIDTH  per-bit clr to bank
reg_ld  output  WIDTH  per-bit Id to bank
reg_d  output  WIDTH  per-bit D to bank
busy  output  1  high while an op is in flight (states APPLY, ACK)
done  output  1  one-cycle pulse, op applied

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, clr_n). clr_n=0 at a rising edge forces state=IDLE, ptr=0, and gnt, reg_st, reg_clr, reg_ld, reg_d, busy, done all 0. Reset beats every other input. Reset during APPLY/ACK abandons the op: no done pulse, and control lines drop on the same edge.
- All outputs are registered. No combinational path from req/op/din to any output.
- States: IDLE, APPLY, ACK.
- IDLE: all outputs 0. If req==0, stay. Otherwise select winner w as the first set req bit searching ptr, ptr+1, ... mod 4. Latch op_w and din_w. Next edge moves to APPLY with:
  - gnt = onehot(w), busy = 1
  - ptr <= (w+1) mod 4
- APPLY (exactly 1 cycle). Controls are driven from the latched op:
  - load: reg_ld = all ones, reg_d = din_w, reg_st = 0, reg_clr = 0
  - set: reg_st = din_w (mask), others 0
  - clear: reg_clr = din_w (mask), others 0
  - nop: all controls 0; grant and done still occur
  - Never assert more than one of reg_st/reg_clr/reg_ld on the same bit.
  - Next edge: ACK.
- ACK (exactly 1 cycle): gnt = 0, all controls 0, done = 1, busy = 1. Next edge: IDLE (done = 0, busy = 0).
- Latency: req sampled at edge k gives gnt/controls during cycle k..k+1 and done during k+1..k+2. Minimum spacing between grants is 3 cycles.
- Handshake:
  - A requester holds req, op and din stable until it sees its gnt, then drops req within the gnt cycle.
  - req, op and din are ignored in APPLY/ACK.
  - A req still high on return to IDLE is treated as a new request.
- Simultaneous requests: only one grant per arbitration. Losers wait; the pointer rotation guarantees each pending requester is granted within 4 arbitrations.
- ptr wraps 3 -> 0.
- Mask value 0 for set/clear is legal and results in no bit change.

Test Plan:
- Reset: clr_n=0 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, done=0, all controls 0. After release, first grant goes to requester 0.
- Single load: req=4'b0100, op[5:4]=00, din2=8'hA5 -> next cycle gnt=4'b0100, reg_ld=8'hFF, reg_d=8'hA5. Following cycle done=1, gnt=0. A bank model then reads 8'hA5.
- Set/clear masks: requester 1 set with mask 8'h0F, then requester 3 clear with mask 8'h03 on a bank holding 8'h00 -> reg_st=8'h0F, then reg_clr=8'h03. Bank ends at 8'h0C, and reg_st, reg_clr, reg_ld never overlap per bit.
- Round-robin fairness: all four req held high and re-raised immediately after each grant -> grant order 0,1,2,3,0. Grants are exactly 3 cycles apart, and each grant is followed by one done pulse.
- Reset mid-op: clr_n=0 on the edge entering ACK -> done never pulses, outputs go 0 that edge, and ptr resets to 0.
- Nop op: req=4'b1000 with op=11 -> gnt=4'b1000 for 1 cycle, all controls 0, done pulses once, and ptr advances to 0.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer for a bank of set/clear/load D flip-flops.
// Four requesters compete. The winner's op drives the bank controls for one
// cycle (APPLY). An acknowledge cycle (ACK) follows, with done pulsed.
//
// Ports:
//   clk      rising-edge clock
//   clr_n    synchronous active-low reset
//   req      request per requester (bit i = requester i)
//   op       2-bit op per requester: 00 load, 01 set, 10 clear, 11 nop
//   din      WIDTH-bit data/mask per requester
//   gnt      one-hot grant, high during APPLY
//   reg_st   per-bit set to bank
//   reg_clr  per-bit clear to bank
//   reg_ld   per-bit load enable to bank
//   reg_d    per-bit data to bank
//   busy     high during APPLY and ACK
//   done     one-cycle pulse during ACK
module dff_bank_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [3:0]         req,
  input  logic [7:0]         op,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   reg_st,
  output logic [WIDTH-1:0]   reg_clr,
  output logic [WIDTH-1:0]   reg_ld,
  output logic [WIDTH-1:0]   reg_d,
  output logic               busy,
  output logic               done
);

  localparam int unsigned N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  state_e           r_state;
  logic [1:0]       r_ptr;

  state_e           w_state_nx;
  logic [1:0]       w_ptr_nx;
  logic [3:0]       w_gnt_nx;
  logic [WIDTH-1:0] w_st_nx;
  logic [WIDTH-1:0] w_clr_nx;
  logic [WIDTH-1:0] w_ld_nx;
  logic [WIDTH-1:0] w_d_nx;
  logic             w_busy_nx;
  logic             w_done_nx;

  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic [1:0]       w_opsel;
  logic [WIDTH-1:0] w_dsel;

  // Winner search: first set req bit starting at ptr, wrapping mod 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Select the winner's op and data.
  always_comb begin
    w_opsel = op[1:0];
    w_dsel  = din[0 +: WIDTH];
    case (w_win)
      2'd0: begin w_opsel = op[1:0]; w_dsel = din[0*WIDTH +: WIDTH]; end
      2'd1: begin w_opsel = op[3:2]; w_dsel = din[1*WIDTH +: WIDTH]; end
      2'd2: begin w_opsel = op[5:4]; w_dsel = din[2*WIDTH +: WIDTH]; end
      default: begin w_opsel = op[7:6]; w_dsel = din[3*WIDTH +: WIDTH]; end
    endcase
  end

  // Next-state and next-output logic. Outputs are registered, so the values
  // computed in IDLE become the APPLY-cycle controls; this acts as the latch
  // of the winner's op and data.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_gnt_nx   = '0;
    w_st_nx    = '0;
    w_clr_nx   = '0;
    w_ld_nx    = '0;
    w_d_nx     = '0;
    w_busy_nx  = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nx = APPLY;
          w_gnt_nx   = 4'(4'b0001 << w_win);
          w_busy_nx  = 1'b1;
          w_ptr_nx   = w_win + 2'd1;
          // Only one control class is ever driven, so bits never overlap.
          case (op_e'(w_opsel))
            OP_LOAD: begin
              w_ld_nx = {WIDTH{1'b1}};
              w_d_nx  = w_dsel;
            end
            OP_SET:  w_st_nx  = w_dsel;
            OP_CLR:  w_clr_nx = w_dsel;
            default: ;
          endcase
        end
      end
      APPLY: begin
        w_state_nx = ACK;
        w_busy_nx  = 1'b1;
        w_done_nx  = 1'b1;
      end
      ACK: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // State, pointer and output registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      gnt     <= '0;
      reg_st  <= '0;
      reg_clr <= '0;
      reg_ld  <= '0;
      reg_d   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      gnt     <= w_gnt_nx;
      reg_st  <= w_st_nx;
      reg_clr <= w_clr_nx;
      reg_ld  <= w_ld_nx;
      reg_d   <= w_d_nx;
      busy    <= w_busy_nx;
      done    <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with a small flop-bank model.
module tb_dff_bank_arbiter;

  localparam int unsigned WIDTH = 8;

  logic               clk;
  logic               clr_n;
  logic [3:0]         req;
  logic [7:0]         op;
  logic [4*WIDTH-1:0] din;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   reg_st;
  logic [WIDTH-1:0]   reg_clr;
  logic [WIDTH-1:0]   reg_ld;
  logic [WIDTH-1:0]   reg_d;
  logic               busy;
  logic               done;

  logic [WIDTH-1:0]   bank;
  logic               ovl;
  int                 n_total;
  int                 n_bad;

  dff_bank_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .req     (req),
    .op      (op),
    .din     (din),
    .gnt     (gnt),
    .reg_st  (reg_st),
    .reg_clr (reg_clr),
    .reg_ld  (reg_ld),
    .reg_d   (reg_d),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank of set/clear/load flops; clear dominates set, set dominates load.
  always @(posedge clk) begin
    for (int b = 0; b < WIDTH; b++) begin
      if (reg_clr[b])     bank[b] <= 1'b0;
      else if (reg_st[b]) bank[b] <= 1'b1;
      else if (reg_ld[b]) bank[b] <= reg_d[b];
    end
    if (((reg_st & reg_clr) | (reg_st & reg_ld) | (reg_clr & reg_ld)) != '0)
      ovl <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One requester issues one op; checks APPLY, ACK and the return to IDLE.
  task automatic run_op(input int r, input logic [1:0] o, input logic [7:0] d,
                        input logic [7:0] e_st, input logic [7:0] e_clr,
                        input logic [7:0] e_ld, input logic [7:0] e_d);
    req = 4'(4'b0001 << r);
    op  = 8'hFF;
    op[2*r +: 2] = o;
    din = '0;
    din[WIDTH*r +: WIDTH] = d;
    @(negedge clk);
    chk("apply_gnt",  32'(gnt), 32'(4'(4'b0001 << r)));
    chk("apply_busy", 32'(busy), 32'd1);
    chk("apply_done", 32'(done), 32'd0);
    chk("apply_st",   32'(reg_st), 32'(e_st));
    chk("apply_clr",  32'(reg_clr), 32'(e_clr));
    chk("apply_ld",   32'(reg_ld), 32'(e_ld));
    chk("apply_d",    32'(reg_d), 32'(e_d));
    req = 4'b0000;
    @(negedge clk);
    chk("ack_gnt",  32'(gnt), 32'd0);
    chk("ack_done", 32'(done), 32'd1);
    chk("ack_busy", 32'(busy), 32'd1);
    chk("ack_ctl",  {reg_st, reg_clr, reg_ld, reg_d}, 32'd0);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    ovl     = 1'b0;
    bank    = '0;
    clr_n   = 1'b0;
    req     = 4'b1111;
    op      = 8'hFF;
    din     = '0;

    // Reset held two cycles with all requests high.
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",  32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ctl",  {reg_st, reg_clr, reg_ld, reg_d}, 32'd0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    chk("first_done", 32'(done), 32'd1);
    @(negedge clk);

    // Single load from requester 2 (ptr now 1).
    run_op(2, 2'b00, 8'hA5, 8'h00, 8'h00, 8'hFF, 8'hA5);
    chk("bank_load", 32'(bank), 32'hA5);

    // Clear everything, then set 0F and clear 03.
    run_op(3, 2'b10, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00);
    chk("bank_zero", 32'(bank), 32'h00);
    run_op(1, 2'b01, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00);
    chk("bank_set", 32'(bank), 32'h0F);
    run_op(3, 2'b10, 8'h03, 8'h00, 8'h03, 8'h00, 8'h00);
    chk("bank_clr", 32'(bank), 32'h0C);

    // Fairness: all four held high with nop ops, ptr starts at 0.
    req = 4'b1111;
    op  = 8'hFF;
    din = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("rr_gnt",  32'(gnt), (k % 3 == 1) ? 32'(4'(4'b0001 << (((k - 1) / 3) % 4))) : 32'd0);
      chk("rr_done", 32'(done), (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k == 13) req = 4'b0000;
    end
    chk("rr_bank", 32'(bank), 32'h0C);

    // Reset on the edge that would enter ACK (ptr is 1).
    req = 4'b0010;
    op  = 8'hF3;
    din = '0;
    din[WIDTH*1 +: WIDTH] = 8'h3C;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h2);
    clr_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_gnt0", 32'(gnt), 32'd0);
    chk("mid_ctl",  {reg_st, reg_clr, reg_ld, reg_d}, 32'd0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("mid_nodone", 32'(done), 32'd0);
    // ptr back to 0: requesters 0 and 3 compete, 0 must win.
    req = 4'b1001;
    op  = 8'hFF;
    @(negedge clk);
    chk("mid_ptr", 32'(gnt), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    // Nop from requester 3 (ptr 1): no controls, one done, ptr wraps to 0.
    run_op(3, 2'b11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("nop_bank", 32'(bank), 32'h3C);
    req = 4'b1111;
    @(negedge clk);
    chk("nop_ptr", 32'(gnt), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    chk("no_overlap", 32'(ovl), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
